// File: rtl/demux_1_8.sv
// Registered 1-to-8 demultiplexer with manual select mode and auto TDM mode.
// Auto mode stages slots 0..6 and publishes the whole frame to Y when slot 7 arrives.
module demux_1_8 #(
    parameter int WIDTH = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     D,
    input  logic                 S0,
    input  logic                 S1,
    input  logic                 S2,
    input  logic                 load,
    input  logic                 auto_mode,
    input  logic                 sync,
    output logic [8*WIDTH-1:0]   Y,
    output logic [2:0]           slot,
    output logic                 frame_valid
);

    logic [8*WIDTH-1:0] y_q, y_d;
    logic [7*WIDTH-1:0] stage_q, stage_d;
    logic [2:0]         slot_q, slot_d;
    logic               fv_q, fv_d;
    logic               mode_q;
    logic [2:0]         sel;
    logic               restart;
    logic [2:0]         fill_slot;

    assign sel = {S2, S1, S0};

    // A mode change or sync abandons the partial frame; stale stage entries are
    // harmless because every slot is rewritten before the next frame completes.
    assign restart   = sync || (auto_mode != mode_q);
    assign fill_slot = restart ? 3'd0 : slot_q;

    always_comb begin
        y_d     = y_q;
        stage_d = stage_q;
        slot_d  = slot_q;
        fv_d    = 1'b0;
        if (!auto_mode) begin
            slot_d = 3'd0;
            if (load) begin
                for (int k = 0; k < 8; k++) begin
                    if (sel == 3'(k)) begin
                        y_d[k*WIDTH +: WIDTH] = D;
                    end
                end
            end
        end else begin
            slot_d = fill_slot;
            if (load) begin
                if (fill_slot == 3'd7) begin
                    y_d    = {D, stage_q};
                    fv_d   = 1'b1;
                    slot_d = 3'd0;
                end else begin
                    for (int k = 0; k < 7; k++) begin
                        if (fill_slot == 3'(k)) begin
                            stage_d[k*WIDTH +: WIDTH] = D;
                        end
                    end
                    slot_d = fill_slot + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q     <= '0;
            stage_q <= '0;
            slot_q  <= 3'd0;
            fv_q    <= 1'b0;
            mode_q  <= 1'b0;
        end else begin
            y_q     <= y_d;
            stage_q <= stage_d;
            slot_q  <= slot_d;
            fv_q    <= fv_d;
            mode_q  <= auto_mode;
        end
    end

    assign Y           = y_q;
    assign slot        = slot_q;
    assign frame_valid = fv_q;

endmodule

// File: tb/tb_demux_1_8.sv
// Scoreboard bench for demux_1_8 (WIDTH=1): stimulus pushes per-edge expectations,
// a negedge monitor pops and compares; key hand-computed values are checked inline.
module tb_demux_1_8;

    logic       clk;
    logic       rst_n;
    logic [0:0] D;
    logic       S0, S1, S2;
    logic       load;
    logic       auto_mode;
    logic       sync;
    logic [7:0] Y;
    logic [2:0] slot;
    logic       frame_valid;

    demux_1_8 #(.WIDTH(1)) dut (
        .clk(clk), .rst_n(rst_n), .D(D), .S0(S0), .S1(S1), .S2(S2),
        .load(load), .auto_mode(auto_mode), .sync(sync),
        .Y(Y), .slot(slot), .frame_valid(frame_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         edge_n;
        logic [7:0] y;
        logic [2:0] s;
        logic       f;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    // reference model state
    logic [7:0] m_y;
    logic [6:0] m_stg;
    logic [2:0] m_slot;
    logic       m_fv;
    logic       m_mode;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].edge_n <= cyc) begin
            e = q.pop_front();
            chk("sb_Y", 32'(Y), 32'(e.y));
            chk("sb_slot", 32'(slot), 32'(e.s));
            chk("sb_frame_valid", 32'(frame_valid), 32'(e.f));
        end
    end

    task automatic model_reset();
        m_y = '0; m_stg = '0; m_slot = '0; m_fv = 1'b0; m_mode = 1'b0;
    endtask

    task automatic step(input logic ld, input logic a, input logic sy,
                        input logic [2:0] sel, input logic d);
        exp_t e;
        logic [2:0] s;
        load = ld; auto_mode = a; sync = sy; D = d;
        {S2, S1, S0} = sel;
        m_fv = 1'b0;
        if (!a) begin
            if (ld) m_y[sel] = d;
            m_slot = 3'd0;
        end else begin
            s = (a != m_mode || sy) ? 3'd0 : m_slot;
            m_slot = s;
            if (ld) begin
                if (s == 3'd7) begin
                    m_y = {d, m_stg};
                    m_fv = 1'b1;
                    m_slot = 3'd0;
                end else begin
                    m_stg[s] = d;
                    m_slot = s + 3'd1;
                end
            end
        end
        m_mode = a;
        e.edge_n = cyc + 1; e.y = m_y; e.s = m_slot; e.f = m_fv;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic auto_samples(input logic [7:0] bits, input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, 3'd0, bits[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int fv_idx[$];
        logic [7:0] pat;

        rst_n = 1'b0; D = '0; {S2, S1, S0} = 3'd0;
        load = 1'b0; auto_mode = 1'b0; sync = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_Y", 32'(Y), 32'h0);
        chk("reset_slot", 32'(slot), 32'h0);
        chk("reset_fv", 32'(frame_valid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // manual sweep: D alternates 1,0 over selects 0..7
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 1'b0, 1'b0, 3'(k), (k % 2 == 0) ? 1'b1 : 1'b0);
            chk("sweep_channel_bit", 32'(Y[k]), (k % 2 == 0) ? 32'h1 : 32'h0);
        end
        chk("sweep_Y", 32'(Y), 32'h55);
        step(1'b0, 1'b0, 1'b0, 3'd3, 1'b1);
        chk("noload_hold_Y", 32'(Y), 32'h55);

        // build 8'hA5 then reset asynchronously mid-cycle
        step(1'b1, 1'b0, 1'b0, 3'd4, 1'b0);
        step(1'b1, 1'b0, 1'b0, 3'd6, 1'b0);
        step(1'b1, 1'b0, 1'b0, 3'd5, 1'b1);
        step(1'b1, 1'b0, 1'b0, 3'd7, 1'b1);
        chk("pre_reset_Y", 32'(Y), 32'hA5);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_Y", 32'(Y), 32'h0);
        chk("async_reset_slot", 32'(slot), 32'h0);
        chk("async_reset_fv", 32'(frame_valid), 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // auto frame 1,1,0,0,1,0,1,1 for slots 0..7
        pat = 8'b1101_0011;
        auto_samples(pat, 7);
        chk("auto_partial_Y", 32'(Y), 32'h0);
        chk("auto_slot7", 32'(slot), 32'h7);
        step(1'b1, 1'b1, 1'b0, 3'd0, pat[7]);
        chk("auto_frame_Y", 32'(Y), 32'hD3);
        chk("auto_frame_fv", 32'(frame_valid), 32'h1);
        step(1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
        chk("auto_fv_drop", 32'(frame_valid), 32'h0);

        // sync with load=0 after 3 samples
        auto_samples(8'hFF, 3);
        step(1'b0, 1'b1, 1'b1, 3'd0, 1'b0);
        chk("sync_slot0", 32'(slot), 32'h0);
        auto_samples(8'h3C, 8);
        chk("sync_frame_Y", 32'(Y), 32'h3C);

        // sync together with load at slot 5
        auto_samples(8'hFF, 5);
        chk("slot5", 32'(slot), 32'h5);
        step(1'b1, 1'b1, 1'b1, 3'd0, 1'b1);
        chk("sync_load_slot1", 32'(slot), 32'h1);
        auto_samples(8'h00, 7);
        chk("sync_load_frame_Y", 32'(Y), 32'h01);

        // mode switch mid-frame
        auto_samples(8'h0F, 4);
        step(1'b1, 1'b0, 1'b0, 3'd6, 1'b1);
        chk("switch_Y6", 32'(Y[6]), 32'h1);
        chk("switch_slot", 32'(slot), 32'h0);
        step(1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
        chk("return_auto_slot", 32'(slot), 32'h0);
        auto_samples(8'hFF, 7);
        chk("switch_7_no_fv", 32'(frame_valid), 32'h0);
        chk("switch_7_Y", 32'(Y), 32'h41);
        step(1'b1, 1'b1, 1'b0, 3'd0, 1'b1);
        chk("switch_full_frame_Y", 32'(Y), 32'hFF);

        // back-to-back frames
        for (int i = 0; i < 24; i++) begin
            step(1'b1, 1'b1, 1'b0, 3'd0, i[0]);
            if (frame_valid) fv_idx.push_back(i);
        end
        chk("b2b_pulses", 32'(fv_idx.size()), 32'd3);
        if (fv_idx.size() == 3) begin
            chk("b2b_spacing_a", 32'(fv_idx[1] - fv_idx[0]), 32'd8);
            chk("b2b_spacing_b", 32'(fv_idx[2] - fv_idx[1]), 32'd8);
        end
        chk("b2b_last_Y", 32'(Y), 32'hAA);
        step(1'b0, 1'b1, 1'b0, 3'd0, 1'b0);

        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
